// File: rtl/wb_commit_buffer.sv
// In-order commit buffer between the WB stage and the register-file write port.
// Define WB_FWD_EN to enable forwarding lookups against pending entries.
module wb_commit_buffer #(
    parameter int XLEN  = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic                     in_we_i,
    input  logic [AW-1:0]            in_rd_i,
    input  logic [XLEN-1:0]          in_data_i,
    output logic                     rf_we_o,
    output logic [AW-1:0]            rf_waddr_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    input  logic                     rf_wready_i,
    input  logic [AW-1:0]            q_rs1_i,
    input  logic [AW-1:0]            q_rs2_i,
    output logic                     fwd1_hit_o,
    output logic                     fwd2_hit_o,
    output logic [XLEN-1:0]          fwd1_data_o,
    output logic [XLEN-1:0]          fwd2_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ready_q;
    logic [XLEN-1:0] data_q [DEPTH];
    logic [AW-1:0]   rd_q   [DEPTH];

    logic full, push, store, pop;

    assign full       = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    // ready_q holds in_ready low for the first cycle after reset release.
    assign in_ready_o = rst_i & ready_q & ~full;
    assign push       = in_valid_i & in_ready_o;
    assign store      = push & in_we_i & (in_rd_i != '0);

    assign rf_we_o    = ~empty_o;
    assign rf_waddr_o = rd_q[rd_ptr_q];
    assign rf_wdata_o = data_q[rd_ptr_q];
    assign pop        = rf_we_o & rf_wready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
        case ({store, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= 1'b1;
        end
    end

    // Storage is intentionally not reset; validity comes from count/pointers.
    always_ff @(posedge clk_i) begin
        if (store) begin
            data_q[wr_ptr_q] <= in_data_i;
            rd_q[wr_ptr_q]   <= in_rd_i;
        end
    end

`ifdef WB_FWD_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd1_hit_o  = 1'b0;
        fwd2_hit_o  = 1'b0;
        fwd1_data_o = '0;
        fwd2_data_o = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q) begin
                if ((q_rs1_i != '0) && (rd_q[idx] == q_rs1_i)) begin
                    fwd1_hit_o  = 1'b1;
                    fwd1_data_o = data_q[idx];
                end
                if ((q_rs2_i != '0) && (rd_q[idx] == q_rs2_i)) begin
                    fwd2_hit_o  = 1'b1;
                    fwd2_data_o = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_fwd_q;

    assign unused_fwd_q = ^{q_rs1_i, q_rs2_i};
    assign fwd1_hit_o   = 1'b0;
    assign fwd2_hit_o   = 1'b0;
    assign fwd1_data_o  = '0;
    assign fwd2_data_o  = '0;
`endif

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed self-checking bench for wb_commit_buffer (DEPTH=2).
// Forwarding expectations follow WB_FWD_EN when it is defined for the build.
module tb_wb_commit_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        in_we_i;
    logic [4:0]  in_rd_i;
    logic [31:0] in_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        rf_wready_i;
    logic [4:0]  q_rs1_i;
    logic [4:0]  q_rs2_i;
    logic        fwd1_hit_o;
    logic        fwd2_hit_o;
    logic [31:0] fwd1_data_o;
    logic [31:0] fwd2_data_o;
    logic [1:0]  count_o;
    logic        empty_o;

    int checks = 0;
    int errors = 0;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    wb_commit_buffer #(.XLEN(32), .AW(5), .DEPTH(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_we_i(in_we_i),
        .in_rd_i(in_rd_i), .in_data_i(in_data_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .rf_wready_i(rf_wready_i), .q_rs1_i(q_rs1_i), .q_rs2_i(q_rs2_i),
        .fwd1_hit_o(fwd1_hit_o), .fwd2_hit_o(fwd2_hit_o),
        .fwd1_data_o(fwd1_data_o), .fwd2_data_o(fwd2_data_o),
        .count_o(count_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic we, input logic [4:0] rd, input logic [31:0] data);
        in_valid_i = 1'b1;
        in_we_i    = we;
        in_rd_i    = rd;
        in_data_i  = data;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; in_valid_i = 1'b0; in_we_i = 1'b0; in_rd_i = '0; in_data_i = '0;
        rf_wready_i = 1'b0; q_rs1_i = 5'd5; q_rs2_i = 5'd0;
        step(); step();
        checks++; if (count_o !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count_o); end
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty_o); end
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", rf_we_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready_o); end
        checks++; if ({fwd1_hit_o, fwd2_hit_o} !== 2'b00) begin errors++; $display("FAIL reset_fwd_hit: got %b expected 00", {fwd1_hit_o, fwd2_hit_o}); end
        checks++; if ((fwd1_data_o | fwd2_data_o) !== 32'h0) begin errors++; $display("FAIL reset_fwd_data: got %h/%h expected 0", fwd1_data_o, fwd2_data_o); end
        rst_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL release_ready_low: got %b expected 0", in_ready_o); end
        step();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL release_ready_high: got %b expected 1", in_ready_o); end
    endtask

    task automatic test_single();
        rf_wready_i = 1'b1;
        offer(1'b1, 5'd5, 32'hDEADBEEF);
        step();
        in_valid_i = 1'b0;
        #1;
        checks++; if (rf_we_o !== 1'b1) begin errors++; $display("FAIL single_rf_we: got %b expected 1", rf_we_o); end
        checks++; if (rf_waddr_o !== 5'd5) begin errors++; $display("FAIL single_waddr: got %0d expected 5", rf_waddr_o); end
        checks++; if (rf_wdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata: got %h expected deadbeef", rf_wdata_o); end
        step();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL single_empty: got %b expected 1", empty_o); end
        checks++; if (rf_we_o !== 1'b0) begin errors++; $display("FAIL single_rf_we_off: got %b expected 0", rf_we_o); end
    endtask

    task automatic test_full();
        rf_wready_i = 1'b0;
        offer(1'b1, 5'd1, 32'hA1); step();
        offer(1'b1, 5'd2, 32'hA2); step();
        offer(1'b1, 5'd3, 32'hA3);
        #1;
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL full_count: got %0d expected 2", count_o); end
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", in_ready_o); end
        step();
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL full_no_take: got %0d expected 2", count_o); end
        rf_wready_i = 1'b1;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b expected 0", in_ready_o); end
        in_valid_i = 1'b0;
        #1;
        checks++; if ({rf_waddr_o, rf_wdata_o} !== {5'd1, 32'hA1}) begin errors++; $display("FAIL drain_first: got %0d:%h expected 1:a1", rf_waddr_o, rf_wdata_o); end
        step();
        checks++; if ({rf_waddr_o, rf_wdata_o} !== {5'd2, 32'hA2}) begin errors++; $display("FAIL drain_second: got %0d:%h expected 2:a2", rf_waddr_o, rf_wdata_o); end
        checks++; if (count_o !== 2'd1) begin errors++; $display("FAIL drain_count: got %0d expected 1", count_o); end
        step();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", empty_o); end
    endtask

    task automatic test_x0();
        rf_wready_i = 1'b1;
        offer(1'b1, 5'd0, 32'h1234);
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", in_ready_o); end
        step();
        checks++; if ({count_o, rf_we_o} !== 3'b000) begin errors++; $display("FAIL x0_count: got %0d/%b expected 0/0", count_o, rf_we_o); end
        offer(1'b0, 5'd7, 32'h7777);
        #1;
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL nowe_ready: got %b expected 1", in_ready_o); end
        step();
        in_valid_i = 1'b0;
        #1;
        checks++; if ({count_o, rf_we_o, empty_o} !== 4'b0001) begin errors++; $display("FAIL nowe_count: got %0d/%b/%b expected 0/0/1", count_o, rf_we_o, empty_o); end
    endtask

    task automatic test_back_to_back();
        rf_wready_i = 1'b0;
        offer(1'b1, 5'd3, 32'h300); step();
        rf_wready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 5'd3, 32'h301 + i);
            #1;
            checks++; if ({count_o, rf_waddr_o, rf_wdata_o} !== {2'd1, 5'd3, 32'h300 + i}) begin
                errors++; $display("FAIL b2b_%0d: got %0d:%0d:%h expected 1:3:%h", i, count_o, rf_waddr_o, rf_wdata_o, 32'h300 + i);
            end
            step();
        end
        in_valid_i = 1'b0;
        #1;
        checks++; if ({count_o, rf_wdata_o} !== {2'd1, 32'h308}) begin errors++; $display("FAIL b2b_last: got %0d:%h expected 1:308", count_o, rf_wdata_o); end
        step();
        checks++; if (empty_o !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b expected 1", empty_o); end
    endtask

    task automatic test_forward();
        rf_wready_i = 1'b0;
        q_rs1_i = 5'd4; q_rs2_i = 5'd0;
        offer(1'b1, 5'd4, 32'h11); step();
        offer(1'b1, 5'd4, 32'h22);
        #1;
        checks++; if ({fwd1_hit_o, fwd1_data_o} !== {FWD, (FWD ? 32'h11 : 32'h0)}) begin errors++; $display("FAIL fwd_no_same_cycle: got %b:%h", fwd1_hit_o, fwd1_data_o); end
        step();
        in_valid_i = 1'b0;
        #1;
        checks++; if (fwd1_hit_o !== FWD) begin errors++; $display("FAIL fwd1_hit: got %b expected %b", fwd1_hit_o, FWD); end
        checks++; if (fwd1_data_o !== (FWD ? 32'h22 : 32'h0)) begin errors++; $display("FAIL fwd1_data: got %h expected %h", fwd1_data_o, FWD ? 32'h22 : 32'h0); end
        checks++; if ({fwd2_hit_o, fwd2_data_o} !== 33'h0) begin errors++; $display("FAIL fwd2_x0: got %b:%h expected 0:0", fwd2_hit_o, fwd2_data_o); end
        q_rs1_i = 5'd9; q_rs2_i = 5'd4;
        #1;
        checks++; if ({fwd1_hit_o, fwd2_hit_o, fwd2_data_o} !== {1'b0, FWD, (FWD ? 32'h22 : 32'h0)}) begin errors++; $display("FAIL fwd_swap: got %b%b:%h", fwd1_hit_o, fwd2_hit_o, fwd2_data_o); end
        q_rs1_i = 5'd4; q_rs2_i = 5'd0;
        rf_wready_i = 1'b1;
        step();
        checks++; if ({fwd1_hit_o, fwd1_data_o} !== {FWD, (FWD ? 32'h22 : 32'h0)}) begin errors++; $display("FAIL fwd_popping: got %b:%h", fwd1_hit_o, fwd1_data_o); end
        step();
        checks++; if ({fwd1_hit_o, empty_o} !== 2'b01) begin errors++; $display("FAIL fwd_drained: got %b%b expected 01", fwd1_hit_o, empty_o); end
    endtask

    task automatic test_mid_reset();
        rf_wready_i = 1'b0;
        offer(1'b1, 5'd8, 32'h88); step();
        offer(1'b1, 5'd9, 32'h99); step();
        in_valid_i = 1'b0;
        #1;
        checks++; if (count_o !== 2'd2) begin errors++; $display("FAIL mid_fill: got %0d expected 2", count_o); end
        rst_i = 1'b0;
        rf_wready_i = 1'b1;
        step();
        rst_i = 1'b1;
        #1;
        checks++; if ({count_o, rf_we_o, in_ready_o, empty_o} !== 5'b00001) begin errors++; $display("FAIL mid_reset: got %0d/%b/%b/%b expected 0/0/0/1", count_o, rf_we_o, in_ready_o, empty_o); end
        step();
        checks++; if (in_ready_o !== 1'b1) begin errors++; $display("FAIL mid_release: got %b expected 1", in_ready_o); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_x0();
        test_back_to_back();
        test_forward();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
